// File: rtl/multi_sqwave_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_sqwave_gen
//  Brief    : CH independent square-wave generators sharing one prescaler;
//             per-channel on/off times are sampled at each period boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_sqwave_gen #(
  parameter int CH       = 2,
  parameter int W        = 8,
  parameter int TICK_DIV = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_sync,
  input  logic [CH*W-1:0] i_m,
  input  logic [CH*W-1:0] i_n,
  output logic [CH-1:0]   o_q,
  output logic [CH-1:0]   o_period_start
);

  localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  logic [c_PRE_W-1:0] r_pre;
  logic               w_tick;
  logic               w_adv;

  assign w_tick = (r_pre == c_PRE_MAX);
  assign w_adv  = w_tick & i_en & ~i_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
    end else if (i_sync) begin
      r_pre <= '0;
    end else if (i_en) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0]   r_m_s, w_m_s_nxt;
    logic [W-1:0]   r_n_s, w_n_s_nxt;
    logic [W-1:0]   w_m, w_n;
    logic           r_q, w_q_nxt;
    logic           r_ps, w_ps_nxt;
    logic           w_eval;

    assign w_m = i_m[k*W +: W];
    assign w_n = i_n[k*W +: W];

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_m_s_nxt   = r_m_s;
      w_n_s_nxt   = r_n_s;
      w_q_nxt     = r_q;
      w_ps_nxt    = 1'b0;
      w_eval      = 1'b0;

      if (i_sync) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end else if (w_adv) begin
        case (r_state)
          ST_IDLE: w_eval = 1'b1;
          ST_HIGH: begin
            if (r_cnt != r_m_s - 1'b1) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end else if (r_n_s != '0) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
              w_q_nxt     = 1'b0;
            end else begin
              w_eval = 1'b1;
            end
          end
          ST_LOW: begin
            if (r_cnt != r_n_s - 1'b1) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end else begin
              w_eval = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end

      // Period boundary: sample new on/off times and pick the first phase
      if (w_eval) begin
        w_m_s_nxt = w_m;
        w_n_s_nxt = w_n;
        w_cnt_nxt = '0;
        if (w_m != '0) begin
          w_state_nxt = ST_HIGH;
          w_q_nxt     = 1'b1;
          w_ps_nxt    = 1'b1;
        end else if (w_n != '0) begin
          w_state_nxt = ST_LOW;
          w_q_nxt     = 1'b0;
          w_ps_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_q_nxt     = 1'b0;
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_m_s   <= '0;
        r_n_s   <= '0;
        r_q     <= 1'b0;
        r_ps    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_m_s   <= w_m_s_nxt;
        r_n_s   <= w_n_s_nxt;
        r_q     <= w_q_nxt;
        r_ps    <= w_ps_nxt;
      end
    end

    assign o_q[k]            = r_q;
    assign o_period_start[k] = r_ps;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_sqwave_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_sqwave_gen
//  Brief    : Directed and randomized bench for multi_sqwave_gen against a
//             period/position reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_sqwave_gen;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int TD = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            sync;
  logic [CH*W-1:0] m_in;
  logic [CH*W-1:0] n_in;
  logic [CH-1:0]   q;
  logic [CH-1:0]   ps;

  int errors = 0;
  int checks = 0;

  // Reference model: enabled-cycle count since origin, per-channel period
  int            en_cnt;
  bit            act [CH];
  int            pos [CH];
  int            pm  [CH];
  int            pn  [CH];
  logic [CH-1:0] exp_q;
  logic [CH-1:0] exp_ps;

  multi_sqwave_gen #(.CH(CH), .W(W), .TICK_DIV(TD)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_sync         (sync),
    .i_m            (m_in),
    .i_n            (n_in),
    .o_q            (q),
    .o_period_start (ps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    en_cnt = 0;
    exp_q  = '0;
    exp_ps = '0;
    for (int k = 0; k < CH; k++) begin
      act[k] = 1'b0;
      pos[k] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst || sync) begin
      model_reset();
    end else begin
      exp_ps = '0;
      if (en) begin
        en_cnt++;
        if (en_cnt % TD == 0) begin
          for (int k = 0; k < CH; k++) begin
            if (act[k]) begin
              pos[k]++;
              if (pos[k] == pm[k] + pn[k]) act[k] = 1'b0;
            end
            if (!act[k]) begin
              pm[k]     = int'(m_in[k*W +: W]);
              pn[k]     = int'(n_in[k*W +: W]);
              pos[k]    = 0;
              act[k]    = (pm[k] + pn[k]) != 0;
              exp_ps[k] = act[k];
            end
            exp_q[k] = act[k] && (pos[k] < pm[k]);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("q", int'(q), int'(exp_q));
    chk("period_start", int'(ps), int'(exp_ps));
  endtask

  task automatic wait_q(input int ch, input logic v, input int lim, output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (q[ch] !== v && c <= lim);
  endtask

  task automatic wait_ps(input int ch, input int lim, output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (ps[ch] !== 1'b1 && c <= lim);
  endtask

  task automatic set_ch(input int ch, input int mv, input int nv);
    m_in[ch*W +: W] = W'(mv);
    n_in[ch*W +: W] = W'(nv);
  endtask

  initial begin
    int c;
    int hi;
    int pc;
    rst  = 1'b1;
    en   = 1'b1;
    sync = 1'b0;
    m_in = '0;
    n_in = '0;
    model_reset();

    // Reset state, then 1/1 waveform on ch0
    set_ch(0, 1, 1);
    repeat (3) step();
    chk("reset_q", int'(q), 0);
    chk("reset_ps", int'(ps), 0);
    rst = 1'b0;
    wait_q(0, 1'b1, 30, c);
    chk("rise_after_reset", c, 10);
    chk("first_pulse", int'(ps[0]), 1);
    wait_q(0, 1'b0, 30, c);
    chk("high_1x1", c, 10);
    wait_q(0, 1'b1, 30, c);
    chk("low_1x1", c, 10);
    chk("pulse_at_rise", int'(ps[0]), 1);

    // Shadowed on/off times: change mid-HIGH takes effect next period
    set_ch(0, 5, 5);
    wait_ps(0, 60, c);
    repeat (20) step();
    set_ch(0, 15, 2);
    wait_q(0, 1'b0, 60, c);
    chk("old_high_rest", c, 30);
    wait_q(0, 1'b1, 80, c);
    chk("old_low", c, 50);
    wait_q(0, 1'b0, 200, c);
    chk("new_high", c, 150);
    wait_q(0, 1'b1, 60, c);
    chk("new_low", c, 20);

    // Constant outputs with periodic pulses, then idle
    set_ch(0, 15, 0);
    set_ch(1, 0, 15);
    wait_ps(0, 200, c);
    wait_ps(0, 200, c);
    chk("const1_period", c, 150);
    wait_ps(1, 200, c);
    wait_ps(1, 200, c);
    chk("const0_period", c, 150);
    set_ch(0, 0, 0);
    set_ch(1, 0, 0);
    repeat (160) step();
    pc = 0;
    repeat (100) begin
      step();
      if (ps != '0) pc++;
    end
    chk("idle_pulses", pc, 0);
    chk("idle_q", int'(q), 0);

    // Enable freeze mid-HIGH stretches the phase
    set_ch(0, 3, 3);
    wait_ps(0, 40, c);
    repeat (10) step();
    en = 1'b0;
    pc = 0;
    repeat (37) begin
      step();
      if (ps[0]) pc++;
    end
    chk("freeze_pulses", pc, 0);
    chk("freeze_q", int'(q[0]), 1);
    en = 1'b1;
    wait_q(0, 1'b0, 40, c);
    hi = 1 + 10 + 37 + c - 1;
    chk("stretched_high", hi, 67);

    // Sync realigns out-of-phase channels, overriding enable
    set_ch(0, 2, 3);
    set_ch(1, 4, 1);
    repeat (37) step();
    sync = 1'b1;
    en   = 1'b0;
    step();
    chk("sync_q", int'(q), 0);
    chk("sync_ps", int'(ps), 0);
    sync = 1'b0;
    en   = 1'b1;
    wait_q(0, 1'b1, 30, c);
    chk("sync_rise", c, 10);
    chk("sync_both_q", int'(q), 3);
    chk("sync_both_ps", int'(ps), 3);

    // Asynchronous reset between edges while ch0 is LOW and ch1 is HIGH
    set_ch(0, 1, 5);
    set_ch(1, 5, 0);
    wait_ps(0, 60, c);
    wait_q(0, 1'b0, 30, c);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_ps", int'(ps), 0);
    model_reset();
    repeat (2) step();
    #2;
    rst = 1'b0;
    wait_q(0, 1'b1, 30, c);
    chk("rise_after_async", c, 10);
    chk("both_after_async", int'(q), 3);

    // Randomized traffic against the model
    for (int seg = 0; seg < 6; seg++) begin
      for (int k = 0; k < CH; k++) set_ch(k, $urandom_range(0, 15), $urandom_range(0, 15));
      repeat (300) begin
        if ($urandom_range(0, 49) == 0) begin
          set_ch($urandom_range(0, CH - 1), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        en   = ($urandom_range(0, 9) != 0);
        sync = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    sync = 1'b0;
    en   = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_sqwave_gen.md
MULTI_SQWAVE_GEN -- requirements
Module: multi_sqwave_gen

Interface
REQ-001 Parameter CH, 2: number of independent square-wave channels, >= 1.
REQ-002 Parameter W, 8: width of each channel's on/off count fields, >= 2.
REQ-003 Parameter TICK_DIV, 10: i_clk cycles per time unit, >= 1.
REQ-004 i_clk  in  1  single clock, rising-edge active.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_en  in  1  run enable; low freezes prescaler and all channels.
REQ-007 i_sync  in  1  synchronous restart of all channels in phase.
REQ-008 i_m  in  CH*W  on-time per channel in time units; channel k at bits [k*W +: W].
REQ-009 i_n  in  CH*W  off-time per channel in time units; same packing as i_m.
REQ-010 o_q  out  CH  registered square-wave output per channel.
REQ-011 o_period_start  out  CH  registered one-cycle pulse marking the start of a new period per channel.

Function
REQ-012 Shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be asserted in the cycle the count equals TICK_DIV-1 (every cycle when TICK_DIV=1).
REQ-013 Each channel SHALL hold state IDLE/HIGH/LOW, a W-bit counter cnt, and shadow registers m_s, n_s.
REQ-014 Channel registers SHALL change only on a tick with i_en=1 and i_sync=0; otherwise all registers hold, and o_period_start SHALL be 0.
REQ-015 Period-boundary evaluation SHALL latch m_s<=i_m[k], n_s<=i_n[k], cnt<=0, then: m>0 -> HIGH, o_q=1, pulse; m=0,n>0 -> LOW, o_q=0, pulse; m=0,n=0 -> IDLE, o_q=0, no pulse.
REQ-016 IDLE on a tick SHALL perform period-boundary evaluation.
REQ-017 HIGH on a tick: cnt<m_s-1 -> cnt++; cnt=m_s-1 and n_s>0 -> LOW, cnt<=0, o_q=0, no pulse; cnt=m_s-1 and n_s=0 -> period-boundary evaluation.
REQ-018 LOW on a tick: cnt<n_s-1 -> cnt++; cnt=n_s-1 -> period-boundary evaluation.
REQ-019 Resulting waveform: o_q high m*TICK_DIV cycles, low n*TICK_DIV cycles; m>0,n=0 -> constant 1; m=0,n>0 -> constant 0; both 0 -> constant 0.
REQ-020 i_m/i_n changes mid-period SHALL NOT affect the current period; they take effect at the next period boundary only.
REQ-021 o_q and o_period_start SHALL update in the same clock edge as the state transition (one-register latency from tick).
REQ-022 i_sync=1 SHALL, on the clock edge, clear prescaler to 0, force all channels to IDLE with cnt=0, o_q=0, o_period_start=0; i_sync overrides i_en.
REQ-023 After i_sync deasserts, first tick SHALL occur TICK_DIV cycles later, all channels starting their periods in the same cycle.
REQ-024 Channels SHALL be fully independent except for the shared prescaler, i_en and i_sync.
REQ-025 cnt arithmetic SHALL be W-bit unsigned; max m or n = 2^W-1 without overflow.

Reset
REQ-026 i_rst=1 SHALL asynchronously set prescaler=0, all channels IDLE, cnt=0, m_s=0, n_s=0, o_q=0, o_period_start=0.
REQ-027 Reset asserted mid-period SHALL abort immediately; after release, behaviour SHALL match REQ-023 (first tick TICK_DIV cycles after release).

Verification (CH=2, W=4, TICK_DIV=10)
REQ-028 ch0 m=1,n=1; reset 3 cycles then release -> o_q[0] rises at cycle 10 after release, 10 high / 10 low repeating; o_period_start[0] pulse every 20 cycles coincident with rising edge.
REQ-029 ch0 m=5,n=5 running, change to m=15,n=2 mid-HIGH -> current 50/50 period completes unchanged, next period 150 high / 20 low.
REQ-030 ch0 m=15,n=0 and ch1 m=0,n=15 -> o_q[0] constant 1 with pulse every 150 cycles; o_q[1] constant 0 with pulse every 150 cycles; m=n=0 -> o_q=0, no pulses.
REQ-031 i_en low for 37 cycles mid-HIGH with m=3,n=3 -> o_q held, high phase extended by exactly 37 cycles, no pulse during freeze.
REQ-032 ch0 m=2,n=3, ch1 m=4,n=1 out of phase; pulse i_sync 1 cycle (also with i_en=0) -> both o_q=0 next edge; both rise and pulse together 10 cycles after i_sync falls.
REQ-033 Assert i_rst asynchronously between clock edges mid-LOW -> outputs 0 immediately, before next edge; restart per REQ-027.
